logic_serial_eval: RTL and testbench



---
 rtl/logic_serial_eval.sv | 129 ++++++++++++
 tb/tb_logic_serial_eval.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/logic_serial_eval.sv
// Bit-serial evaluator of a run-time selected 2-input boolean function over two
// WIDTH-bit operands, one bit per clock, with population count of the result.
module logic_serial_eval #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [3:0]       tt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic [CNT_W-1:0] pop
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r, state_nxt_s;
  logic [WIDTH-1:0] x_r, y_r, shadow_r, s_r;
  logic [3:0]       tt_r;
  logic [IDX_W-1:0] idx_r;
  logic [CNT_W-1:0] cnt_r, pop_r;
  logic             busy_r, done_r;

  logic             bit_s, last_s;
  logic [WIDTH-1:0] shadow_upd_s;
  logic [CNT_W-1:0] cnt_upd_s;

  // Current result bit and the shadow/count as they look after this bit
  always_comb begin
    bit_s        = tt_r[{x_r[idx_r], y_r[idx_r]}];
    last_s       = (idx_r == IDX_W'(WIDTH - 1));
    shadow_upd_s = shadow_r;
    shadow_upd_s[idx_r] = bit_s;
    cnt_upd_s    = cnt_r + {{(CNT_W-1){1'b0}}, bit_s};
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_nxt_s = RUN;
        else       state_nxt_s = IDLE;
      end
      RUN: begin
        if (last_s) state_nxt_s = DONE;
        else        state_nxt_s = RUN;
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_nxt_s;
  end

  // Datapath: operand capture, serial evaluation and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_r      <= {WIDTH{1'b0}};
      y_r      <= {WIDTH{1'b0}};
      tt_r     <= 4'b0000;
      idx_r    <= {IDX_W{1'b0}};
      shadow_r <= {WIDTH{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
      s_r      <= {WIDTH{1'b0}};
      pop_r    <= {CNT_W{1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            x_r      <= x;
            y_r      <= y;
            tt_r     <= tt;
            idx_r    <= {IDX_W{1'b0}};
            shadow_r <= {WIDTH{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            busy_r   <= 1'b1;
          end else begin
            busy_r   <= 1'b0;
          end
        end
        RUN: begin
          shadow_r <= shadow_upd_s;
          cnt_r    <= cnt_upd_s;
          busy_r   <= 1'b1;
          // idx saturates at the last bit; the state change ends the run
          if (last_s) begin
            s_r    <= shadow_upd_s;
            pop_r  <= cnt_upd_s;
            done_r <= 1'b1;
          end else begin
            idx_r  <= idx_r + IDX_W'(1);
          end
        end
        DONE: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
        end
        default: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign s    = s_r;
  assign pop  = pop_r;

endmodule

// File: tb/tb_logic_serial_eval.sv
// Directed self-checking bench for logic_serial_eval (WIDTH=8).
module tb_logic_serial_eval;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] x = 8'h00, y = 8'h00;
  logic [3:0] tt = 4'b0000;
  logic       busy, done;
  logic [7:0] s;
  logic [3:0] pop;

  int n_cmp = 0;
  int n_bad = 0;

  logic_serial_eval #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x(x), .y(y), .tt(tt),
    .busy(busy), .done(done), .s(s), .pop(pop)
  );

  always #5 clk = ~clk;

  // Launch one evaluation and report latency (negedges after capture edge), busy
  // in the first cycle, s during RUN, and s/pop in the done cycle.
  task automatic do_eval(input logic [7:0] xa, input logic [7:0] ya, input logic [3:0] tta,
                         output int lat, output logic busy1, output logic [7:0] s_mid,
                         output logic [7:0] s_o, output logic [3:0] pop_o);
    @(negedge clk);
    x = xa; y = ya; tt = tta; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    x = ~xa; y = ~ya; tt = ~tta;
    lat = 0; busy1 = 1'b0; s_mid = 8'hxx; s_o = 8'hxx; pop_o = 4'hx;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) begin busy1 = busy; s_mid = s; end
      if (done) begin lat = k; s_o = s; pop_o = pop; break; end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({busy, done, s, pop} !== 14'h0) begin
        n_bad++; $display("FAIL reset_hold: got busy=%b done=%b s=%h pop=%0d want 0 0 00 0", busy, done, s, pop);
      end
    end
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({busy, done, s, pop} !== 14'h0) begin
        n_bad++; $display("FAIL reset_idle: got busy=%b done=%b s=%h pop=%0d want 0 0 00 0", busy, done, s, pop);
      end
    end
  endtask

  task automatic test_and_not;
    int lat; logic b1; logic [7:0] sm, so; logic [3:0] po;
    do_eval(8'h0F, 8'h55, 4'b0010, lat, b1, sm, so, po);
    n_cmp++; if (lat !== 9) begin n_bad++; $display("FAIL andnot_latency: got %0d want 9", lat); end
    n_cmp++; if (b1 !== 1'b1) begin n_bad++; $display("FAIL andnot_busy: got %b want 1", b1); end
    n_cmp++; if (sm !== 8'h00) begin n_bad++; $display("FAIL andnot_s_hold: got %h want 00", sm); end
    n_cmp++; if (so !== 8'h50) begin n_bad++; $display("FAIL andnot_s: got %h want 50", so); end
    n_cmp++; if (po !== 4'd2) begin n_bad++; $display("FAIL andnot_pop: got %0d want 2", po); end
    @(negedge clk);
    n_cmp++;
    if ({busy, done} !== 2'b00) begin
      n_bad++; $display("FAIL andnot_after: got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_xor_const;
    logic [7:0] xv [3] = '{8'hA5, 8'hA5, 8'hA5};
    logic [7:0] yv [3] = '{8'h0F, 8'h0F, 8'h0F};
    logic [3:0] tv [3] = '{4'b0110, 4'b1111, 4'b0000};
    logic [7:0] se [3] = '{8'hAA, 8'hFF, 8'h00};
    logic [3:0] pe [3] = '{4'd4, 4'd8, 4'd0};
    logic [7:0] prev = 8'h50;
    int lat; logic b1; logic [7:0] sm, so; logic [3:0] po;
    for (int i = 0; i < 3; i++) begin
      do_eval(xv[i], yv[i], tv[i], lat, b1, sm, so, po);
      n_cmp++; if (lat !== 9) begin n_bad++; $display("FAIL xor_latency[%0d]: got %0d want 9", i, lat); end
      n_cmp++; if (sm !== prev) begin n_bad++; $display("FAIL xor_s_hold[%0d]: got %h want %h", i, sm, prev); end
      n_cmp++; if (so !== se[i]) begin n_bad++; $display("FAIL xor_s[%0d]: got %h want %h", i, so, se[i]); end
      n_cmp++; if (po !== pe[i]) begin n_bad++; $display("FAIL xor_pop[%0d]: got %0d want %0d", i, po, pe[i]); end
      prev = se[i];
    end
  endtask

  task automatic test_busy_protect;
    int dones = 0; logic [7:0] so = 8'hxx; logic [3:0] po = 4'hx;
    @(negedge clk);
    x = 8'h3C; y = 8'hF0; tt = 4'b1000; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      if (done) begin dones++; so = s; po = pop; end
      if (k == 3 || k == 7) begin
        start = 1'b1; x = 8'($urandom); y = 8'($urandom); tt = 4'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    n_cmp++; if (dones !== 1) begin n_bad++; $display("FAIL protect_dones: got %0d want 1", dones); end
    n_cmp++; if (so !== 8'h30) begin n_bad++; $display("FAIL protect_s: got %h want 30", so); end
    n_cmp++; if (po !== 4'd2) begin n_bad++; $display("FAIL protect_pop: got %0d want 2", po); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL protect_idle: got busy=%b want 0", busy); end
  endtask

  task automatic test_back_to_back;
    int dones = 0; int last_k = 0;
    @(negedge clk);
    x = 8'hFF; y = 8'hF0; tt = 4'b1000; start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (done) begin
        dones++;
        n_cmp++;
        if (k !== last_k + 9 + ((dones > 1) ? 1 : 0)) begin
          n_bad++; $display("FAIL b2b_spacing: got done at %0d want %0d", k, last_k + 9 + ((dones > 1) ? 1 : 0));
        end
        n_cmp++;
        if (s !== 8'hF0 || pop !== 4'd4) begin
          n_bad++; $display("FAIL b2b_result: got s=%h pop=%0d want F0 4", s, pop);
        end
        last_k = k;
      end
    end
    start = 1'b0;
    n_cmp++; if (dones !== 3) begin n_bad++; $display("FAIL b2b_count: got %0d want 3", dones); end
    repeat (12) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_idle: got busy=%b want 0", busy); end
  endtask

  task automatic test_reset_mid_run;
    int dones = 0; int lat; logic b1; logic [7:0] sm, so; logic [3:0] po;
    @(negedge clk);
    x = 8'hFF; y = 8'hFF; tt = 4'b1000; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, s, pop} !== 14'h0) begin
      n_bad++; $display("FAIL midrst_clear: got busy=%b done=%b s=%h pop=%0d want 0 0 00 0", busy, done, s, pop);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done) dones++;
    end
    n_cmp++; if (dones !== 0) begin n_bad++; $display("FAIL midrst_nodone: got %0d want 0", dones); end
    n_cmp++; if (s !== 8'h00) begin n_bad++; $display("FAIL midrst_s: got %h want 00", s); end
    do_eval(8'h0F, 8'h55, 4'b0110, lat, b1, sm, so, po);
    n_cmp++; if (lat !== 9) begin n_bad++; $display("FAIL midrst_latency: got %0d want 9", lat); end
    n_cmp++; if (so !== 8'h5A) begin n_bad++; $display("FAIL midrst_s_new: got %h want 5A", so); end
    n_cmp++; if (po !== 4'd4) begin n_bad++; $display("FAIL midrst_pop_new: got %0d want 4", po); end
  endtask

  initial begin
    test_reset();
    test_and_not();
    test_xor_const();
    test_busy_protect();
    test_back_to_back();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
